// File: rtl/delaybuffer_pkg.sv
// Shared width helpers and channel-id type for the delay-buffer round-robin arbiter.
package delaybuffer_pkg;

    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int b);
        return $clog2(b + 1);
    endfunction

    localparam int CHANS_DEF = 4;

    typedef logic [chan_w(CHANS_DEF)-1:0] chan_id_t;

endpackage

// File: rtl/rr_priority_select.sv
// Wrapping priority scan: finds the first set request at or after a start index.
module rr_priority_select
    import delaybuffer_pkg::*;
#(
    parameter  int chans_p = 4,
    localparam int CHAN_W  = chan_w(chans_p)
) (
    input  logic [chans_p-1:0] i_req,
    input  logic [CHAN_W-1:0]  i_start,
    output logic               o_found,
    output logic [CHAN_W-1:0]  o_grant
);

    always_comb begin : scan
        int idx;
        o_found = 1'b0;
        o_grant = '0;
        idx     = 0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = chans_p - 1; i >= 0; i--) begin
            idx = int'(i_start) + i;
            if (idx >= chans_p) idx = idx - chans_p;
            if (i_req[idx]) begin
                o_found = 1'b1;
                o_grant = CHAN_W'(idx);
            end
        end
    end

endmodule

// File: rtl/delaybuffer_rr_arbiter.sv
// Round-robin arbiter with bounded burst hold feeding a one-entry registered
// output stage tagged with the source channel.
module delaybuffer_rr_arbiter
    import delaybuffer_pkg::*;
#(
    parameter  int chans_p = 4,
    parameter  int width_p = 8,
    parameter  int burst_p = 4,
    localparam int CHAN_W  = chan_w(chans_p),
    localparam int CNT_W   = cnt_w(burst_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [chans_p-1:0]         valid_i,
    input  logic [chans_p*width_p-1:0] data_i,
    output logic [chans_p-1:0]         ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    output logic [CHAN_W-1:0]          chan_o,
    input  logic                       ready_i
);

    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(chans_p - 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(burst_p);

    logic                r_valid;
    logic [width_p-1:0]  r_data;
    logic [CHAN_W-1:0]   r_chan;
    logic [CHAN_W-1:0]   r_last;
    logic [CNT_W-1:0]    r_cnt;

    logic [CHAN_W-1:0]   w_start;
    logic [CHAN_W-1:0]   w_grant;
    logic [CHAN_W-1:0]   w_sel;
    logic [width_p-1:0]  w_data;
    logic                w_found;
    logic                w_hold;
    logic                w_load;
    logic                w_accept;

    assign w_start = (r_last == LAST_CHAN) ? '0 : r_last + 1'b1;

    rr_priority_select #(.chans_p(chans_p)) u_select (
        .i_req   (valid_i),
        .i_start (w_start),
        .o_found (w_found),
        .o_grant (w_grant)
    );

    // r_cnt==0 only right after reset: no burst in progress, so channel 0 wins.
    assign w_hold   = valid_i[r_last] && (r_cnt != '0) && (r_cnt < BURST_MAX);
    assign w_sel    = w_hold ? r_last : w_grant;
    // No handshake completes while reset is asserted; that beat would be lost.
    assign w_load   = reset_i && (ready_i || !r_valid);
    assign w_accept = w_load && w_found;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_data  = '0;
        ready_o = '0;
        for (int k = 0; k < chans_p; k++) begin
            if (w_sel == CHAN_W'(k)) begin
                w_data     = data_i[k*width_p +: width_p];
                ready_o[k] = w_accept;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_last  <= LAST_CHAN;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_chan  <= w_sel;
            if (w_hold) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_last <= w_sel;
                r_cnt  <= CNT_W'(1);
            end
        end else if (w_load) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign chan_o  = r_chan;

endmodule

// File: tb/tb_delaybuffer_rr_arbiter.sv
// Self-checking bench: behavioural round-robin model feeds a scoreboard queue,
// a separate monitor pops and compares each beat the arbiter hands downstream.
module tb_delaybuffer_rr_arbiter;
    import delaybuffer_pkg::*;

    localparam int C  = 4;
    localparam int W  = 8;
    localparam int B  = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [C-1:0]   valid_i;
    logic [C*W-1:0] data_i;
    logic           ready_i;
    logic [C-1:0]   ready_o;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic [CW-1:0]  chan_o;

    always #5 clk = ~clk;

    delaybuffer_rr_arbiter #(.chans_p(C), .width_p(W), .burst_p(B)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .chan_o  (chan_o),
        .ready_i (ready_i)
    );

    typedef struct packed {
        chan_id_t     chan;
        logic [W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference state: who owns the current burst, how many beats it has had,
    // and whether the output stage holds a beat.
    int    m_owner;
    int    m_beats;
    bit    m_full;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluated mid-cycle with inputs stable: predicts ready_o and the beat
    // that the coming clock edge should capture.
    task automatic model_step();
        int           sel;
        bit           can_take;
        logic [C-1:0] exp_rdy;
        if (!reset_i) begin
            exp_q.delete();
            m_owner = C - 1;
            m_beats = 0;
            m_full  = 0;
            check("ready_o_in_reset", ready_o, 0);
            return;
        end
        check("valid_o", valid_o, m_full);
        can_take = ready_i || !m_full;
        sel = -1;
        if (m_beats > 0 && m_beats < B && valid_i[m_owner]) begin
            sel = m_owner;
        end else begin
            for (int k = 1; k <= C; k++) begin
                if (sel < 0 && valid_i[(m_owner + k) % C]) sel = (m_owner + k) % C;
            end
        end
        exp_rdy = (can_take && sel >= 0) ? (C'(1) << sel) : '0;
        check("ready_o", ready_o, exp_rdy);
        if (can_take) begin
            if (sel >= 0) begin
                exp_q.push_back({CW'(sel), data_i[sel*W +: W]});
                m_full = 1;
                if (sel == m_owner && m_beats > 0 && m_beats < B) begin
                    m_beats++;
                end else begin
                    m_owner = sel;
                    m_beats = 1;
                end
            end else begin
                m_full = 0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [C-1:0] v, input logic rdy);
        reset_i = rst;
        valid_i = v;
        ready_i = rdy;
        for (int k = 0; k < C; k++) data_i[k*W +: W] = W'($urandom);
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a beat leaves the stage when valid_o and ready_i meet outside reset.
    always @(negedge clk) begin
        beat_t e;
        if (reset_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got chan %0d data %0h expected none", chan_o, data_o);
            end else begin
                e = exp_q.pop_front();
                check("chan_o", chan_o, e.chan);
                check("data_o", data_o, e.data);
            end
        end
    end

    logic [W-1:0]  held_d;
    logic [CW-1:0] held_c;

    initial begin
        reset_i = 1'b0;
        valid_i = '0;
        ready_i = 1'b0;
        data_i  = '0;
        m_owner = C - 1;
        m_beats = 0;
        m_full  = 0;
        @(posedge clk);
        #1;

        // Reset held with all channels requesting.
        repeat (3) step(1'b0, 4'hF, 1'b1);
        check("rst_valid_o", valid_o, 0);
        check("rst_chan_o", chan_o, 0);
        step(1'b1, 4'hF, 1'b1);
        check("first_beat_valid", valid_o, 1);
        check("first_beat_chan", chan_o, 0);

        // All valid: bursts of B per channel in order, wrapping back to 0.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 4'hF, 1'b1);
            check("rr_sequence", chan_o, (k / B) % C);
        end

        // Lone requester on ch2: continuous re-grant, no bubbles; then ch0 joins.
        step(1'b0, 4'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 4'b0100, 1'b1);
            check("lone_ch2_chan", chan_o, 2);
            check("lone_ch2_valid", valid_o, 1);
        end
        repeat (4) step(1'b1, 4'b0101, 1'b1);
        check("ch0_after_ch2_burst", chan_o, 0);

        // Backpressure mid-burst: output stage must hold.
        repeat (2) step(1'b1, 4'hF, 1'b1);
        held_d = data_o;
        held_c = chan_o;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, C'($urandom), 1'b0);
            check("stall_data_o", data_o, held_d);
            check("stall_chan_o", chan_o, held_c);
        end
        repeat (6) step(1'b1, 4'hF, 1'b1);

        // Ch1 drops mid-burst, grant moves to ch2; ch1 then waits its turn.
        step(1'b0, 4'h0, 1'b1);
        repeat (2) step(1'b1, 4'b0110, 1'b1);
        check("ch1_burst", chan_o, 1);
        step(1'b1, 4'b0100, 1'b1);
        check("ch1_drop_to_ch2", chan_o, 2);
        repeat (6) step(1'b1, 4'b0110, 1'b1);

        // Reset while a beat is held under backpressure: beat is discarded.
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b0);
        step(1'b0, 4'hF, 1'b0);
        check("rst_drops_beat", valid_o, 0);
        step(1'b1, 4'hF, 1'b1);
        check("rst_restart_ch0", chan_o, 0);

        // Randomized traffic, stalls and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            step(logic'(($urandom % 100) != 0), C'($urandom), logic'(($urandom % 4) != 0));
        end

        // Drain and confirm every predicted beat was seen.
        repeat (3) step(1'b1, 4'h0, 1'b1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
